spi_register_bank: RTL and testbench
====================================

# spi_register_bank

Register-file stage directly downstream of the SPI slave interface. Consumes the slave's received word and new-data flag, decodes a command word plus optional write-data words per chip-select frame, and owns a bank of `2**ADDR_WIDTH` registers. It drives the slave's transmit word for next-frame readback. A host port on the system clock reads and writes the bank and is notified of SPI writes.

## Interface
- `DATA_WIDTH`, 16: SPI word width. Must match the slave interface.
- `ADDR_WIDTH`, 4: register address width. Constraint: `ADDR_WIDTH <= DATA_WIDTH-1`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cs` in 1: raw SPI chip select, active low. Asynchronous; synchronised internally.
- `new_data_flag` in 1: slave's raw new-data flag. Asynchronous; synchronised internally.
- `word_in` in DATA_WIDTH: slave's received word, already two-flop synchronised to `clk`.
- `data_to_send` out DATA_WIDTH: transmit word for the slave's next frame.
- `host_addr` in ADDR_WIDTH: host read/write address.
- `host_we` in 1: host write enable.
- `host_wdata` in DATA_WIDTH: host write data.
- `host_rdata` out DATA_WIDTH: registered read of `reg[host_addr]`.
- `spi_wr_strobe` out 1: one-cycle pulse per SPI register write.
- `spi_wr_addr` out ADDR_WIDTH: address of the last SPI write.
- `frame_active` out 1: high while synchronised `cs` is low.

## Operation
- Synchronisers:
  - `cs` passes through 3 flops.
  - `new_data_flag` passes through 3 flops. The extra stage guarantees `word_in` has settled.
- Word event: rising edge of the synchronised flag while synchronised `cs` is low.
  - If synchronised `cs` is high in the same cycle, the edge is ignored (partial word at frame end).
- FSM states:
  - IDLE → CMD when synchronised `cs` falls.
  - CMD, on a word event, decodes `word_in`:
    - bit `DATA_WIDTH-1` = 1 (write): load `ptr` = `word_in[ADDR_WIDTH-1:0]`, go to WR.
    - bit `DATA_WIDTH-1` = 0 (read): load `data_to_send` <= `reg[word_in[ADDR_WIDTH-1:0]]`, go to RD.
    - Bits between the MSB and the address field are ignored.
  - WR, on each word event: `reg[ptr]` <= `word_in`; pulse `spi_wr_strobe`; `spi_wr_addr` <= `ptr`; then advance `ptr` (see Configuration).
  - RD: further words are ignored. The frame carries command only.
  - Any state → IDLE when synchronised `cs` rises. This abort takes priority over a same-cycle word event.
- Readback model:
  - The slave loads `data_to_send` only while `cs` is high.
  - A read issued in frame N is therefore shifted out during frame N+1.
  - `data_to_send` holds its snapshot until the next read command. Later writes to that register do not update it.
- Address arithmetic: `ptr` is ADDR_WIDTH wide and wraps from `2**ADDR_WIDTH-1` to 0.
- Host port:
  - `host_rdata` <= `reg[host_addr]` every cycle.
  - `host_we` writes `reg[host_addr]`.
  - If an SPI write and a host write hit the same address in the same cycle, the SPI write wins and the host write is dropped. Writes to different addresses both complete.
- Reset values:
  - All registers 0; `data_to_send` 0; `host_rdata` 0.
  - `spi_wr_strobe` 0; `spi_wr_addr` 0; `frame_active` 0.
  - `ptr` 0; FSM in IDLE; synchroniser flops 0 except the `cs` chain, which resets to 1 (idle).
- Reset mid-frame returns the FSM to IDLE. The rest of that frame is ignored until `cs` next falls.

## Timing
- Word event: 4 clk after the raw flag rises (3 sync stages plus 1 edge-detect stage).
- SPI register write: completes 1 clk after the word event, i.e. 5 clk after the flag. `spi_wr_strobe` is high in that same cycle.
- Read command: `data_to_send` is valid 5 clk after the flag.
  - The master must hold `cs` low ≥ 6 clk after the final SCK edge of the command word.
  - SCK word period must be ≥ 8 clk.
- `frame_active`: follows raw `cs` with 3 clk latency.
- `host_rdata`: 1 clk read latency. A same-cycle write returns the old value.

## Configuration
- `SPI_REGBANK_AUTOINC_EN` defined: `ptr` increments (with wrap) after each SPI data write, enabling burst writes.
- `SPI_REGBANK_AUTOINC_EN` undefined: `ptr` stays fixed for the whole frame, so every data word overwrites the same register.

## Test plan
- Reset asserted mid-frame → all outputs and registers read 0; the next frame's first word is decoded as a command.
- Frame: `0x8003, 0x1111, 0x2222` with AUTOINC → `reg[3]`=0x1111, `reg[4]`=0x2222, two strobes with `spi_wr_addr` 3 then 4. Without AUTOINC → `reg[3]`=0x2222 and `reg[4]` unchanged.
- Write to address 15 with 3 data words (ADDR_WIDTH=4, AUTOINC) → writes land at 15, 0, 1.
- Host writes `reg[5]`=0xBEEF, then frame `0x0005` → `data_to_send`=0xBEEF within 5 clk of the flag. A following SPI write to `reg[5]` leaves `data_to_send` at 0xBEEF.
- SPI write and `host_we` both to address 2 in the same cycle → `reg[2]` holds the SPI word. Host write to address 7 in the same cycle also lands.
- `cs` rises during a partial second word (flag rises with `cs`) → no write, no strobe, FSM returns to IDLE.

Source files
------------

// File: rtl/spi_register_bank.sv
// SPI command/data decoder and register bank behind an SPI slave, with a host port; data_to_send valid 5 clk after flag, no backpressure.
// Define SPI_REGBANK_AUTOINC_EN to advance the write pointer after each SPI data word (burst writes).
module spi_register_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  new_data_flag,
  input  logic [DATA_WIDTH-1:0] word_in,
  output logic [DATA_WIDTH-1:0] data_to_send,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_we,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  spi_wr_strobe,
  output logic [ADDR_WIDTH-1:0] spi_wr_addr,
  output logic                  frame_active
);

  localparam int NREGS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                state_q;
  logic [2:0]            cs_sync_q;
  logic [2:0]            flag_sync_q;
  logic                  flag_prev_q;
  logic                  word_evt_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] data_to_send_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic                  spi_wr_strobe_q;
  logic [ADDR_WIDTH-1:0] spi_wr_addr_q;
  logic                  spi_we_d;
  logic                  cs_s;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  assign cs_s     = cs_sync_q[2];
  assign cmd_addr = word_in[ADDR_WIDTH-1:0];

  assign data_to_send  = data_to_send_q;
  assign host_rdata    = host_rdata_q;
  assign spi_wr_strobe = spi_wr_strobe_q;
  assign spi_wr_addr   = spi_wr_addr_q;
  assign frame_active  = ~cs_s;

  // Third flag stage gives word_in time to settle before the event is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= 3'b111;
      flag_sync_q <= 3'b000;
      flag_prev_q <= 1'b0;
      word_evt_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], cs};
      flag_sync_q <= {flag_sync_q[1:0], new_data_flag};
      flag_prev_q <= flag_sync_q[2];
      word_evt_q  <= flag_sync_q[2] & ~flag_prev_q & ~cs_s;
    end
  end

  always_comb begin
`ifdef SPI_REGBANK_AUTOINC_EN
    ptr_d = ptr_q + 1'b1;
`else
    ptr_d = ptr_q;
`endif
    spi_we_d = (state_q == WR) && word_evt_q && !cs_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      data_to_send_q  <= '0;
      spi_wr_strobe_q <= 1'b0;
      spi_wr_addr_q   <= '0;
    end else begin
      spi_wr_strobe_q <= 1'b0;
      // A frame end overrides any word event landing in the same cycle.
      if (state_q != IDLE && cs_s) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (!cs_s) state_q <= CMD;
          CMD: begin
            if (word_evt_q) begin
              if (word_in[DATA_WIDTH-1]) begin
                ptr_q   <= cmd_addr;
                state_q <= WR;
              end else begin
                data_to_send_q <= regs_q[cmd_addr];
                state_q        <= RD;
              end
            end
          end
          WR: begin
            if (word_evt_q) begin
              spi_wr_strobe_q <= 1'b1;
              spi_wr_addr_q   <= ptr_q;
              ptr_q           <= ptr_d;
            end
          end
          RD:      state_q <= RD;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // SPI write takes precedence over a host write to the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      host_rdata_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (spi_we_d && ptr_q == ADDR_WIDTH'(i)) begin
          regs_q[i] <= word_in;
        end else if (host_we && host_addr == ADDR_WIDTH'(i)) begin
          regs_q[i] <= host_wdata;
        end
      end
      host_rdata_q <= regs_q[host_addr];
    end
  end

endmodule

// File: tb/tb_spi_register_bank.sv
// Randomised bench for spi_register_bank against a frame-level model of the register bank.
module tb_spi_register_bank;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        new_data_flag;
  logic [15:0] word_in;
  logic [15:0] data_to_send;
  logic [3:0]  host_addr;
  logic        host_we;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        spi_wr_strobe;
  logic [3:0]  spi_wr_addr;
  logic        frame_active;

  spi_register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .new_data_flag(new_data_flag),
    .word_in(word_in), .data_to_send(data_to_send),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .spi_wr_strobe(spi_wr_strobe),
    .spi_wr_addr(spi_wr_addr), .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int strobe_cnt;
  int exp_strobes;

  logic [15:0] mregs [16];
  logic [15:0] exp_dts;
  bit          cmd_seen;
  bit          wr_mode;
  logic [3:0]  mptr;
  logic [15:0] fq [$];

  always @(negedge clk) if (spi_wr_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    exp_dts  = 16'h0;
    cmd_seen = 1'b0;
    wr_mode  = 1'b0;
    mptr     = 4'h0;
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [15:0] exp, input string tag);
    host_addr = a;
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 16; i++) read_reg(4'(i), mregs[i], "reg_dump");
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    logic [15:0] old;
    old        = mregs[a];
    mregs[a]   = d;
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(posedge clk);
    #1 host_we = 1'b0;
    @(negedge clk);
    check("host_rd_old", 32'(host_rdata), 32'(old));
    @(posedge clk);
    @(negedge clk);
    check("host_rd_new", 32'(host_rdata), 32'(d));
  endtask

  task automatic start_frame();
    cs       = 1'b0;
    cmd_seen = 1'b0;
    wr_mode  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) check("frame_active_lat", 32'(frame_active), 0);
      if (k == 3) check("frame_active_on", 32'(frame_active), 1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) check("frame_active_hold", 32'(frame_active), 1);
      if (k == 3) check("frame_active_off", 32'(frame_active), 0);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmd_seen = 1'b0;
    wr_mode  = 1'b0;
  endtask

  // One SPI word; optional host write placed in the same cycle as the resulting SPI write.
  task automatic send_word(input logic [15:0] w, input bit hw, input logic [3:0] ha, input logic [15:0] hd);
    bit          do_wr;
    logic [3:0]  waddr;
    logic [15:0] dts_old;
    do_wr   = 1'b0;
    waddr   = mptr;
    dts_old = exp_dts;
    if (!cmd_seen) begin
      cmd_seen = 1'b1;
      if (w[15]) begin
        wr_mode = 1'b1;
        mptr    = w[3:0];
      end else begin
        exp_dts = mregs[w[3:0]];
      end
    end else if (wr_mode) begin
      do_wr       = 1'b1;
      waddr       = mptr;
      mregs[mptr] = w;
`ifdef SPI_REGBANK_AUTOINC_EN
      mptr = mptr + 4'd1;
`endif
    end
    if (hw && !(do_wr && ha == waddr)) mregs[ha] = hd;
    if (do_wr) exp_strobes++;
    word_in       = w;
    new_data_flag = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 4 && hw) begin
        host_addr  = ha;
        host_wdata = hd;
        host_we    = 1'b1;
      end
      if (k == 5) host_we = 1'b0;
      @(negedge clk);
      if (k == 4) begin
        check("strobe_early", 32'(spi_wr_strobe), 0);
        check("dts_hold", 32'(data_to_send), 32'(dts_old));
      end
      if (k == 5) begin
        check("strobe", 32'(spi_wr_strobe), 32'(do_wr));
        if (do_wr) check("wr_addr", 32'(spi_wr_addr), 32'(waddr));
        check("dts", 32'(data_to_send), 32'(exp_dts));
      end
      if (k == 6) check("strobe_width", 32'(spi_wr_strobe), 0);
    end
    new_data_flag = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame();
    start_frame();
    foreach (fq[i]) send_word(fq[i], 1'b0, 4'h0, 16'h0);
    end_frame();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; strobe_cnt = 0; exp_strobes = 0;
    reset = 1'b1; cs = 1'b1; new_data_flag = 1'b0; word_in = 16'h0;
    host_addr = 4'h0; host_we = 1'b0; host_wdata = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dts", 32'(data_to_send), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);
    check("rst_strobe", 32'(spi_wr_strobe), 0);
    check("rst_wr_addr", 32'(spi_wr_addr), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    dump_regs();

    // Write command followed by two data words
    fq = '{16'h8003, 16'h1111, 16'h2222};
    run_frame();
`ifdef SPI_REGBANK_AUTOINC_EN
    read_reg(4'd3, 16'h1111, "burst_reg3");
    read_reg(4'd4, 16'h2222, "burst_reg4");
`else
    read_reg(4'd3, 16'h2222, "fixed_reg3");
    read_reg(4'd4, 16'h0000, "fixed_reg4");
`endif

    // Pointer wrap from the top address
    fq = '{16'h800F, 16'hA001, 16'hA002, 16'hA003};
    run_frame();
`ifdef SPI_REGBANK_AUTOINC_EN
    read_reg(4'd15, 16'hA001, "wrap_reg15");
    read_reg(4'd0, 16'hA002, "wrap_reg0");
    read_reg(4'd1, 16'hA003, "wrap_reg1");
`else
    read_reg(4'd15, 16'hA003, "wrap_reg15");
    read_reg(4'd0, 16'h0000, "wrap_reg0");
`endif

    // Read snapshot survives later SPI writes
    host_write(4'd5, 16'hBEEF);
    fq = '{16'h0005};
    run_frame();
    check("read_snapshot", 32'(data_to_send), 32'h0000BEEF);
    fq = '{16'h8005, 16'h1234};
    run_frame();
    check("snapshot_held", 32'(data_to_send), 32'h0000BEEF);
    read_reg(4'd5, 16'h1234, "reg5_overwritten");

    // SPI vs host collisions: same address loses, different address lands
    start_frame();
    send_word(16'h8002, 1'b0, 4'h0, 16'h0);
    send_word(16'h5A5A, 1'b1, 4'd2, 16'hDEAD);
    end_frame();
    read_reg(4'd2, 16'h5A5A, "collide_spi_wins");
    start_frame();
    send_word(16'h8002, 1'b0, 4'h0, 16'h0);
    send_word(16'h6B6B, 1'b1, 4'd7, 16'h7777);
    end_frame();
    read_reg(4'd2, 16'h6B6B, "collide_spi_reg2");
    read_reg(4'd7, 16'h7777, "collide_host_reg7");

    // Partial word coinciding with cs rising is dropped
    start_frame();
    send_word(16'h8006, 1'b0, 4'h0, 16'h0);
    send_word(16'h4321, 1'b0, 4'h0, 16'h0);
    word_in = 16'h5555; new_data_flag = 1'b1; cs = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("partial_no_strobe", 32'(spi_wr_strobe), 0);
    end
    new_data_flag = 1'b0;
    repeat (6) @(negedge clk);
    cmd_seen = 1'b0; wr_mode = 1'b0;
    check("partial_frame_off", 32'(frame_active), 0);
    fq = '{16'h0006};
    run_frame();
    check("partial_then_read", 32'(data_to_send), 32'h00004321);
    dump_regs();

    // Reset in the middle of a word
    start_frame();
    send_word(16'h8001, 1'b0, 4'h0, 16'h0);
    send_word(16'hAAAA, 1'b0, 4'h0, 16'h0);
    word_in = 16'hBBBB; new_data_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_dts", 32'(data_to_send), 0);
    check("midrst_host_rdata", 32'(host_rdata), 0);
    check("midrst_strobe", 32'(spi_wr_strobe), 0);
    check("midrst_wr_addr", 32'(spi_wr_addr), 0);
    check("midrst_frame_active", 32'(frame_active), 0);
    cs = 1'b1; new_data_flag = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    dump_regs();
    fq = '{16'h8002, 16'h4321};
    run_frame();
    read_reg(4'd2, 16'h4321, "post_reset_cmd");

    // Randomised frames and host traffic
    for (int f = 0; f < 30; f++) begin
      logic [15:0] cmd;
      int          n;
      cmd = 16'($urandom);
      n   = $urandom_range(0, 3);
      start_frame();
      send_word(cmd, 1'b0, 4'h0, 16'h0);
      for (int j = 0; j < n; j++)
        send_word(16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 16'($urandom));
      end_frame();
      if ($urandom_range(0, 1) == 1) host_write(4'($urandom), 16'($urandom));
      if (f % 10 == 9) dump_regs();
    end

    check("strobe_total", 32'(strobe_cnt), 32'(exp_strobes));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
